// File: rtl/alu_pkg.sv
// Shared ALU definitions: opcode encodings and the default datapath width.
package alu_pkg;

  localparam int ALU_WIDTH = 8;

  typedef enum logic [2:0] {
    OP_ADD = 3'b000,
    OP_SUB = 3'b001,
    OP_AND = 3'b010,
    OP_OR  = 3'b011,
    OP_XOR = 3'b100,
    OP_NOT = 3'b101,
    OP_INC = 3'b110,
    OP_DEC = 3'b111
  } alu_op_e;

endpackage

// File: rtl/alu_core.sv
// Combinational ALU datapath: next result plus carry/borrow, zero and signed
// overflow flags. No state; the wrapper owns handshake and registers.
module alu_core
  import alu_pkg::*;
#(
  parameter int WIDTH = ALU_WIDTH
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [2:0]       alu_op,
  output logic [WIDTH-1:0] res,
  output logic             carry,
  output logic             zero,
  output logic             ovf
);

  localparam int MSB = WIDTH - 1;

  alu_op_e          op;
  logic [WIDTH:0]   sum;
  logic [WIDTH:0]   diff;
  logic [WIDTH-1:0] one;

  assign op   = alu_op_e'(alu_op);
  assign one  = {{(WIDTH-1){1'b0}}, 1'b1};
  // Extra top bit carries out of ADD and holds the borrow of SUB.
  assign sum  = {1'b0, a} + {1'b0, b};
  assign diff = {1'b0, a} - {1'b0, b};

  // Opcode decode; logic ops force carry and overflow low.
  always_comb begin
    res   = '0;
    carry = 1'b0;
    ovf   = 1'b0;
    unique case (op)
      OP_ADD: begin
        res   = sum[WIDTH-1:0];
        carry = sum[WIDTH];
        ovf   = (a[MSB] == b[MSB]) && (res[MSB] != a[MSB]);
      end
      OP_SUB: begin
        res   = diff[WIDTH-1:0];
        carry = diff[WIDTH];
        ovf   = (a[MSB] != b[MSB]) && (res[MSB] != a[MSB]);
      end
      OP_AND: res = a & b;
      OP_OR:  res = a | b;
      OP_XOR: res = a ^ b;
      OP_NOT: res = ~a;
      OP_INC: begin
        res   = a + one;
        carry = &a;
        ovf   = ~a[MSB] & (&a[MSB-1:0]);
      end
      OP_DEC: begin
        res   = a - one;
        carry = ~|a;
        ovf   = a[MSB] & ~|a[MSB-1:0];
      end
      default: res = '0;
    endcase
  end

  assign zero = ~|res;

endmodule

// File: rtl/alu.sv
// Registered ALU: one-cycle latency, valid handshake, flags held while idle.
// Optional feature: define ALU_NEG_FLAG_EN to add the registered 'negative'
// output (copy of result MSB).
module alu
  import alu_pkg::*;
#(
  parameter int WIDTH = ALU_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [2:0]       alu_op,
  output logic [WIDTH-1:0] result,
  output logic             carry_out,
  output logic             zero,
  output logic             overflow,
  output logic             out_valid
`ifdef ALU_NEG_FLAG_EN
  ,output logic            negative
`endif
);

  localparam int STAGES = 1;

  logic [WIDTH-1:0] nxt_res;
  logic             nxt_carry;
  logic             nxt_zero;
  logic             nxt_ovf;
  logic [STAGES:0]  vld_pipe;

  alu_core #(.WIDTH(WIDTH)) u_core (
    .a      (a),
    .b      (b),
    .alu_op (alu_op),
    .res    (nxt_res),
    .carry  (nxt_carry),
    .zero   (nxt_zero),
    .ovf    (nxt_ovf)
  );

  // Valid shift register; reset kills any operation in flight.
  assign vld_pipe[0] = in_valid;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) vld_pipe[STAGES:1] <= '0;
    else     vld_pipe[STAGES:1] <= vld_pipe[STAGES-1:0];
  end
  assign out_valid = vld_pipe[STAGES];

  // Result and flags load only on an accepted operation, otherwise hold.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      result    <= '0;
      carry_out <= 1'b0;
      zero      <= 1'b0;
      overflow  <= 1'b0;
    end else if (in_valid) begin
      result    <= nxt_res;
      carry_out <= nxt_carry;
      zero      <= nxt_zero;
      overflow  <= nxt_ovf;
    end
  end

`ifdef ALU_NEG_FLAG_EN
  // Sign flag tracks the result register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)           negative <= 1'b0;
    else if (in_valid) negative <= nxt_res[WIDTH-1];
  end
`endif

endmodule

// File: tb/tb_alu.sv
// Directed table-driven bench for alu (WIDTH=8), plus reset/hold sequences.
module tb_alu;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic [7:0] a, b;
  logic [2:0] alu_op;
  logic [7:0] result;
  logic       carry_out, zero, overflow, out_valid;
`ifdef ALU_NEG_FLAG_EN
  logic       negative;
`endif

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [2:0] op;
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] res;
    logic       c;
    logic       z;
    logic       o;
  } vec_t;

  vec_t vecs[$];

  alu #(.WIDTH(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .a         (a),
    .b         (b),
    .alu_op    (alu_op),
    .result    (result),
    .carry_out (carry_out),
    .zero      (zero),
    .overflow  (overflow),
    .out_valid (out_valid)
`ifdef ALU_NEG_FLAG_EN
    ,.negative (negative)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic add_v(input logic [2:0] op, input logic [7:0] va, input logic [7:0] vb,
                       input logic [7:0] r, input logic c, input logic z, input logic o);
    vec_t v;
    v.op = op; v.a = va; v.b = vb; v.res = r; v.c = c; v.z = z; v.o = o;
    vecs.push_back(v);
  endtask

  task automatic chk_out(input string tag, input logic [7:0] r, input logic c,
                         input logic z, input logic o, input logic v);
    chk({tag, ".result"},    32'(result),    32'(r));
    chk({tag, ".carry"},     32'(carry_out), 32'(c));
    chk({tag, ".zero"},      32'(zero),      32'(z));
    chk({tag, ".overflow"},  32'(overflow),  32'(o));
    chk({tag, ".out_valid"}, 32'(out_valid), 32'(v));
`ifdef ALU_NEG_FLAG_EN
    chk({tag, ".negative"},  32'(negative),  32'(r[7]));
`endif
  endtask

  initial begin
    // op, a, b, result, carry, zero, overflow
    add_v(3'b000, 8'h15, 8'h23, 8'h38, 0, 0, 0);
    add_v(3'b000, 8'h7F, 8'h01, 8'h80, 0, 0, 1);
    add_v(3'b000, 8'hFF, 8'h01, 8'h00, 1, 1, 0);
    add_v(3'b000, 8'h80, 8'h80, 8'h00, 1, 1, 1);
    add_v(3'b001, 8'h50, 8'h10, 8'h40, 0, 0, 0);
    add_v(3'b001, 8'h10, 8'h50, 8'hC0, 1, 0, 0);
    add_v(3'b001, 8'h80, 8'h01, 8'h7F, 0, 0, 1);
    add_v(3'b001, 8'h33, 8'h33, 8'h00, 0, 1, 0);
    add_v(3'b010, 8'hAA, 8'h0F, 8'h0A, 0, 0, 0);
    add_v(3'b011, 8'hF0, 8'h0F, 8'hFF, 0, 0, 0);
    add_v(3'b100, 8'hFF, 8'h0F, 8'hF0, 0, 0, 0);
    add_v(3'b100, 8'h5A, 8'h5A, 8'h00, 0, 1, 0);
    add_v(3'b101, 8'h55, 8'h12, 8'hAA, 0, 0, 0);
    add_v(3'b101, 8'hFF, 8'h34, 8'h00, 0, 1, 0);
    add_v(3'b110, 8'h7F, 8'hFF, 8'h80, 0, 0, 1);
    add_v(3'b110, 8'hFF, 8'h00, 8'h00, 1, 1, 0);
    add_v(3'b110, 8'h10, 8'h77, 8'h11, 0, 0, 0);
    add_v(3'b111, 8'h01, 8'hFF, 8'h00, 0, 1, 0);
    add_v(3'b111, 8'h00, 8'h01, 8'hFF, 1, 0, 0);
    add_v(3'b111, 8'h80, 8'h80, 8'h7F, 0, 0, 1);

    rst = 1'b1; in_valid = 1'b1; a = 8'h15; b = 8'h23; alu_op = 3'b000;
    #2;
    chk_out("reset", 8'h00, 0, 0, 0, 0);
    // in_valid ignored across an edge while rst is high
    @(posedge clk); #1;
    chk_out("rst_ignores_valid", 8'h00, 0, 0, 0, 0);
    @(negedge clk);
    rst = 1'b0; in_valid = 1'b0;

    // Back-to-back stream, one result per cycle
    foreach (vecs[i]) begin
      @(negedge clk);
      in_valid = 1'b1; a = vecs[i].a; b = vecs[i].b; alu_op = vecs[i].op;
      @(posedge clk); #1;
      chk_out($sformatf("vec%0d", i), vecs[i].res, vecs[i].c, vecs[i].z, vecs[i].o, 1'b1);
    end

    // Idle: outputs hold last (DEC 0x80 -> 0x7F, ovf), out_valid drops
    @(negedge clk);
    in_valid = 1'b0; a = 8'h00; b = 8'h00; alu_op = 3'b000;
    @(posedge clk); #1;
    chk_out("hold1", 8'h7F, 0, 0, 1, 0);
    @(posedge clk); #1;
    chk_out("hold2", 8'h7F, 0, 0, 1, 0);

    // Load a nonzero state, then reset between edges with an op in flight
    @(negedge clk);
    in_valid = 1'b1; a = 8'hFF; b = 8'h00; alu_op = 3'b110;
    @(posedge clk); #1;
    chk_out("pre_rst", 8'h00, 1, 1, 0, 1);
    a = 8'h15; b = 8'h23; alu_op = 3'b000;
    #2 rst = 1'b1;
    #1;
    chk_out("async_rst", 8'h00, 0, 0, 0, 0);
    @(posedge clk); #1;
    chk_out("inflight_discard", 8'h00, 0, 0, 0, 0);
    @(negedge clk);
    rst = 1'b0; in_valid = 1'b0;
    @(posedge clk); #1;
    chk_out("post_rst_hold", 8'h00, 0, 0, 0, 0);

    // First op after release is accepted
    @(negedge clk);
    in_valid = 1'b1; a = 8'h15; b = 8'h23; alu_op = 3'b000;
    @(posedge clk); #1;
    chk_out("first_after_rst", 8'h38, 0, 0, 0, 1);
    @(negedge clk);
    in_valid = 1'b0;
    @(posedge clk); #1;
    chk_out("final_hold", 8'h38, 0, 0, 0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
